controller: RTL and testbench

- Debug controller between the host-side command decoder (UART link) and the RV32 MCU.
- Accepts one debug command at a time: pause, resume, reset, register-file/memory read/write, breakpoint add/remove.
- Turns each command into single-cycle strobes to the MCU and waits for the MCU to finish.
- Keeps a breakpoint table and pauses the MCU on its own when the program counter hits a breakpoint.

---
 rtl/debug_pkg.sv | 56 +++++
 rtl/controller_brk_table.sv | 80 ++++++++
 rtl/controller.sv | 178 +++++++++++++++++
 tb/tb_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types for the debug controller.
// Opcodes, controller states and MCU strobe bundle.
package debug_pkg;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        PAUSE     = 4'd1,
        RESUME    = 4'd2,
        RESET     = 4'd3,
        REG_RD    = 4'd4,
        REG_WR    = 4'd5,
        MEM_RD    = 4'd6,
        MEM_WR    = 4'd7,
        BR_PT_ADD = 4'd8,
        BR_PT_RM  = 4'd9
    } DEBUG_FN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pause;
        logic resume;
        logic reset;
        logic rf_rd;
        logic rf_wr;
        logic mem_rd;
        logic mem_wr;
    } mcu_stb_t;

    localparam logic [31:0] BRK_FULL = 32'hFFFF_FFFF;

    function automatic mcu_stb_t fn_strobe(input DEBUG_FN fn);
        mcu_stb_t s;
        s = '0;
        case (fn)
            PAUSE:   s.pause  = 1'b1;
            RESUME:  s.resume = 1'b1;
            RESET:   s.reset  = 1'b1;
            REG_RD:  s.rf_rd  = 1'b1;
            REG_WR:  s.rf_wr  = 1'b1;
            MEM_RD:  s.mem_rd = 1'b1;
            MEM_WR:  s.mem_wr = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic is_read(input DEBUG_FN fn);
        return (fn == REG_RD) || (fn == MEM_RD);
    endfunction

endpackage

// File: rtl/controller_brk_table.sv
// Breakpoint table: valid/address slots with parallel compare.
// Gives pc hit, lowest free slot, existing match and remove count.
module brk_table
    import debug_pkg::*;
#(
    parameter int NUM_BRK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic [31:0] addr_i,
    input  logic        add_i,
    input  logic        rm_i,
    output logic        hit_o,
    output logic        match_o,
    output logic [31:0] match_idx_o,
    output logic        free_o,
    output logic [31:0] free_idx_o,
    output logic [31:0] rm_cnt_o
);

    logic [NUM_BRK-1:0] valid_q, valid_d;
    logic [31:0]        slot_q [NUM_BRK];
    logic [31:0]        slot_d [NUM_BRK];

    // Parallel compare; descending scan leaves the lowest index.
    always_comb begin
        hit_o       = 1'b0;
        match_o     = 1'b0;
        match_idx_o = '0;
        free_o      = 1'b0;
        free_idx_o  = '0;
        rm_cnt_o    = '0;
        for (int i = NUM_BRK - 1; i >= 0; i--) begin
            if (valid_q[i] && slot_q[i] == pc_i) begin
                hit_o = 1'b1;
            end
            if (valid_q[i] && slot_q[i] == addr_i) begin
                match_o     = 1'b1;
                match_idx_o = 32'(i);
                rm_cnt_o    = rm_cnt_o + 32'd1;
            end
            if (!valid_q[i]) begin
                free_o     = 1'b1;
                free_idx_o = 32'(i);
            end
        end
    end

    // Add writes the lowest free slot unless already present; remove clears all matches.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        for (int i = 0; i < NUM_BRK; i++) begin
            if (add_i && !match_o && free_o && free_idx_o == 32'(i)) begin
                valid_d[i] = 1'b1;
                slot_d[i]  = addr_i;
            end
            if (rm_i && valid_q[i] && slot_q[i] == addr_i) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Table registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BRK; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_BRK; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/controller.sv
// Debug controller between host command decoder and RV32 MCU.
// One command at a time; autonomous pause on breakpoint hit.
module controller
    import debug_pkg::*;
#(
    parameter int NUM_BRK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  DEBUG_FN     debug_fn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic        mcu_busy,
    input  logic [31:0] d_in,
    output logic        pause,
    output logic        resume,
    output logic        reset,
    output logic        rf_rd,
    output logic        rf_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mcu_addr,
    output logic [31:0] mcu_wdata,
    output logic        out_valid,
    output logic [31:0] d_rd,
    output logic        ctrlr_busy
);

    ctrl_state_e state_q, state_d;
    DEBUG_FN     fn_q, fn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        paused_q, paused_d;
    logic        int_q, int_d;
    mcu_stb_t    stb_q, stb_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] d_rd_q, d_rd_d;

    logic        add_en, rm_en;
    logic        pc_hit, match, free;
    logic [31:0] match_idx, free_idx, rm_cnt;
    logic        brk_hit, accept;

    brk_table #(
        .NUM_BRK(NUM_BRK)
    ) u_brk (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_i       (pc),
        .addr_i     (addr_q),
        .add_i      (add_en),
        .rm_i       (rm_en),
        .hit_o      (pc_hit),
        .match_o    (match),
        .match_idx_o(match_idx),
        .free_o     (free),
        .free_idx_o (free_idx),
        .rm_cnt_o   (rm_cnt)
    );

    assign brk_hit    = (state_q == IDLE) && !paused_q && pc_hit;
    assign ctrlr_busy = (state_q != IDLE) || brk_hit;
    assign accept     = in_valid && !ctrlr_busy && (debug_fn != NONE);

    assign pause     = stb_q.pause;
    assign resume    = stb_q.resume;
    assign reset     = stb_q.reset;
    assign rf_rd     = stb_q.rf_rd;
    assign rf_wr     = stb_q.rf_wr;
    assign mem_rd    = stb_q.mem_rd;
    assign mem_wr    = stb_q.mem_wr;
    assign mcu_addr  = addr_q;
    assign mcu_wdata = wdata_q;
    assign out_valid = out_valid_q;
    assign d_rd      = d_rd_q;

    // Next-state, strobe and completion logic.
    always_comb begin
        state_d     = state_q;
        fn_d        = fn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        paused_d    = paused_q;
        int_d       = int_q;
        stb_d       = '0;
        out_valid_d = 1'b0;
        d_rd_d      = d_rd_q;
        add_en      = 1'b0;
        rm_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (brk_hit) begin
                    state_d     = ISSUE;
                    fn_d        = PAUSE;
                    int_d       = 1'b1;
                    stb_d.pause = 1'b1;
                    paused_d    = 1'b1;
                end else if (accept) begin
                    state_d = ISSUE;
                    fn_d    = debug_fn;
                    addr_d  = addr;
                    wdata_d = wdata;
                    int_d   = 1'b0;
                    stb_d   = fn_strobe(debug_fn);
                    if (debug_fn == PAUSE) begin
                        paused_d = 1'b1;
                    end
                    if (debug_fn == RESUME || debug_fn == RESET) begin
                        paused_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (fn_strobe(fn_q) != '0) begin
                    state_d = WAIT;
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    case (fn_q)
                        BR_PT_ADD: begin
                            add_en = 1'b1;
                            if (match) begin
                                d_rd_d = match_idx;
                            end else if (free) begin
                                d_rd_d = free_idx;
                            end else begin
                                d_rd_d = BRK_FULL;
                            end
                        end
                        BR_PT_RM: begin
                            rm_en  = 1'b1;
                            d_rd_d = rm_cnt;
                        end
                        default: d_rd_d = BRK_FULL;
                    endcase
                end
            end
            WAIT: begin
                if (!mcu_busy) begin
                    state_d     = IDLE;
                    out_valid_d = !int_q;
                    if (!int_q) begin
                        d_rd_d = is_read(fn_q) ? d_in : 32'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fn_q        <= NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            paused_q    <= 1'b0;
            int_q       <= 1'b0;
            stb_q       <= '0;
            out_valid_q <= 1'b0;
            d_rd_q      <= '0;
        end else begin
            state_q     <= state_d;
            fn_q        <= fn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            paused_q    <= paused_d;
            int_q       <= int_d;
            stb_q       <= stb_d;
            out_valid_q <= out_valid_d;
            d_rd_q      <= d_rd_d;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Directed testbench for the debug controller.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_controller;
    import debug_pkg::*;

    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    DEBUG_FN     debug_fn;
    logic [31:0] addr, wdata, pc, d_in;
    logic        in_valid, mcu_busy;
    logic        pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr;
    logic [31:0] mcu_addr, mcu_wdata, d_rd;
    logic        out_valid, ctrlr_busy;
    logic [6:0]  strb;

    int tests = 0;
    int fails = 0;

    controller #(.NUM_BRK(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .debug_fn  (debug_fn),
        .addr      (addr),
        .wdata     (wdata),
        .in_valid  (in_valid),
        .pc        (pc),
        .mcu_busy  (mcu_busy),
        .d_in      (d_in),
        .pause     (pause),
        .resume    (resume),
        .reset     (reset),
        .rf_rd     (rf_rd),
        .rf_wr     (rf_wr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mcu_addr  (mcu_addr),
        .mcu_wdata (mcu_wdata),
        .out_valid (out_valid),
        .d_rd      (d_rd),
        .ctrlr_busy(ctrlr_busy)
    );

    assign strb = {pause, resume, reset, rf_rd, rf_wr, mem_rd, mem_wr};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns in the ISSUE cycle.
    task automatic send(input DEBUG_FN fn, input logic [31:0] a,
                        input logic [31:0] w);
        debug_fn = fn;
        addr     = a;
        wdata    = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        debug_fn = NONE;
    endtask

    // Table-style command: out_valid one cycle after acceptance.
    task automatic tbl(input string tag, input DEBUG_FN fn,
                       input logic [31:0] a, input logic [31:0] exp);
        send(fn, a, 32'd0);
        check({tag, " issue strobes"}, 32'(strb), 32'd0);
        check({tag, " issue out_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " d_rd"}, d_rd, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        debug_fn = NONE;
        addr     = '0;
        wdata    = '0;
        in_valid = 1'b0;
        pc       = 32'h1000;
        mcu_busy = 1'b0;
        d_in     = '0;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(ctrlr_busy), 32'd0);
        check("rst d_rd", d_rd, 32'd0);
        check("rst strobes", 32'(strb), 32'd0);
        rst_n = 1'b1;
        tick();

        // PAUSE with MCU busy for several cycles
        send(PAUSE, 32'd0, 32'd0);
        check("pause strobe", 32'(strb), 32'b1000000);
        check("pause busy issue", 32'(ctrlr_busy), 32'd1);
        mcu_busy = 1'b1;
        tick();
        check("pause strobe drop", 32'(strb), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause wait ov", 32'(out_valid), 32'd0);
            check("pause wait busy", 32'(ctrlr_busy), 32'd1);
        end
        mcu_busy = 1'b0;
        tick();
        check("pause done ov", 32'(out_valid), 32'd1);
        check("pause done d_rd", d_rd, 32'd0);
        check("pause idle busy", 32'(ctrlr_busy), 32'd0);
        tick();
        check("pause ov pulse", 32'(out_valid), 32'd0);

        // Breakpoint add, duplicate add; paused so pc match is inert
        pc = 32'h10;
        tbl("add10", BR_PT_ADD, 32'h10, 32'd0);
        check("paused no hit", 32'(ctrlr_busy), 32'd0);
        tbl("add10 dup", BR_PT_ADD, 32'h10, 32'd0);

        // RESUME then run into breakpoint at 0x10
        pc = 32'h0;
        send(RESUME, 32'd0, 32'd0);
        check("resume strobe", 32'(strb), 32'b0100000);
        tick();
        tick();
        check("resume ov", 32'(out_valid), 32'd1);
        check("resume idle", 32'(ctrlr_busy), 32'd0);
        pc = 32'h4;
        tick();
        pc = 32'h8;
        tick();
        pc = 32'hC;
        tick();
        check("pre-bp busy", 32'(ctrlr_busy), 32'd0);
        pc = 32'h10;
        #1;
        check("bp hit busy", 32'(ctrlr_busy), 32'd1);
        tick();
        check("bp pause strobe", 32'(strb), 32'b1000000);
        check("bp no ov issue", 32'(out_valid), 32'd0);
        tick();
        check("bp wait strobe", 32'(strb), 32'd0);
        check("bp no ov wait", 32'(out_valid), 32'd0);
        tick();
        check("bp no ov done", 32'(out_valid), 32'd0);
        check("bp paused idle", 32'(ctrlr_busy), 32'd0);

        // MEM_RD with MCU data
        send(MEM_RD, 32'h100, 32'd0);
        check("memrd strobe", 32'(strb), 32'b0000010);
        check("memrd addr", mcu_addr, 32'h100);
        addr     = 32'h0;
        mcu_busy = 1'b1;
        d_in     = 32'hBAD;
        tick();
        check("memrd wait ov", 32'(out_valid), 32'd0);
        check("memrd addr held", mcu_addr, 32'h100);
        mcu_busy = 1'b0;
        d_in     = 32'h28;
        tick();
        check("memrd ov", 32'(out_valid), 32'd1);
        check("memrd data", d_rd, 32'h28);

        // Fill table, overflow, remove, refill lowest slot
        for (int i = 1; i < NB; i++) begin
            tbl("fill", BR_PT_ADD, 32'h10 + 32'(16 * i), 32'(i));
        end
        tbl("add full", BR_PT_ADD, 32'h300, BRK_FULL);
        tbl("rm10", BR_PT_RM, 32'h10, 32'd1);
        tbl("rm10 again", BR_PT_RM, 32'h10, 32'd0);
        tbl("add300", BR_PT_ADD, 32'h300, 32'd0);
        tbl("unknown op", DEBUG_FN'(4'd12), 32'h0, BRK_FULL);

        // Resume at pc 0x10: removed, so no hit
        send(RESUME, 32'd0, 32'd0);
        tick();
        tick();
        check("resume2 ov", 32'(out_valid), 32'd1);
        check("rm no hit busy", 32'(ctrlr_busy), 32'd0);
        tick();
        check("rm no pause 1", 32'(strb), 32'd0);
        tick();
        check("rm no pause 2", 32'(strb), 32'd0);

        // Breakpoint beats a pending host command; host retries
        pc       = 32'h300;
        debug_fn = REG_RD;
        addr     = 32'h5;
        in_valid = 1'b1;
        tick();
        check("prio pause", 32'(strb), 32'b1000000);
        tick();
        check("prio wait busy", 32'(ctrlr_busy), 32'd1);
        tick();
        check("prio no ov", 32'(out_valid), 32'd0);
        tick();
        check("retry rf_rd", 32'(strb), 32'b0001000);
        check("retry addr", mcu_addr, 32'h5);
        in_valid = 1'b0;
        debug_fn = NONE;
        d_in     = 32'h55;
        tick();
        tick();
        check("rfrd ov", 32'(out_valid), 32'd1);
        check("rfrd data", d_rd, 32'h55);

        // Reset during WAIT drops the command
        send(MEM_WR, 32'h200, 32'hDEAD);
        check("memwr strobe", 32'(strb), 32'b0000001);
        check("memwr wdata", mcu_wdata, 32'hDEAD);
        mcu_busy = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check("wrst ov", 32'(out_valid), 32'd0);
        check("wrst strobes", 32'(strb), 32'd0);
        check("wrst busy", 32'(ctrlr_busy), 32'd0);
        check("wrst addr", mcu_addr, 32'd0);
        check("wrst wdata", mcu_wdata, 32'd0);
        check("wrst d_rd", d_rd, 32'd0);
        rst_n    = 1'b1;
        mcu_busy = 1'b0;
        tick();
        check("post rst ov", 32'(out_valid), 32'd0);
        check("table empty", 32'(ctrlr_busy), 32'd0);
        tbl("rm empty", BR_PT_RM, 32'h300, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
